// File: rtl/demux16b3_reg.sv
// Registered 1-to-8 demultiplexer for 16-bit words with per-slot valid/ack holding registers.
// Optional saturating stall counter on port stall_cnt, enabled by defining DEMUX16B3_STALLCNT_EN.
module demux16b3_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic [2:0]  in_sel,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out0,
  output logic [15:0] out1,
  output logic [15:0] out2,
  output logic [15:0] out3,
  output logic [15:0] out4,
  output logic [15:0] out5,
  output logic [15:0] out6,
  output logic [15:0] out7,
  output logic [7:0]  out_valid,
  input  logic [7:0]  out_ack
`ifdef DEMUX16B3_STALLCNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  logic [15:0] hold [8];
  logic        accept;

  // A full slot being acked this cycle can take a new word on the same edge.
  assign in_ready = !rst && (!out_valid[in_sel] || out_ack[in_sel]);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 8'h00;
      for (int k = 0; k < 8; k++) begin
        hold[k] <= 16'h0000;
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (accept && (in_sel == k[2:0])) begin
          hold[k]      <= in_data;
          out_valid[k] <= 1'b1;
        end else if (out_valid[k] && out_ack[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

  assign out0 = hold[0];
  assign out1 = hold[1];
  assign out2 = hold[2];
  assign out3 = hold[3];
  assign out4 = hold[4];
  assign out5 = hold[5];
  assign out6 = hold[6];
  assign out7 = hold[7];

`ifdef DEMUX16B3_STALLCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 16'h0000;
    end else if (in_valid && !in_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_demux16b3_reg.sv
// Scoreboard bench for demux16b3_reg: accepted words queue per slot, a negedge monitor
// pops and compares each word when its consumer acks it; directed checks cover the rest.
module tb_demux16b3_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic [2:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic [7:0]  out_valid;
  logic [7:0]  out_ack;
`ifdef DEMUX16B3_STALLCNT_EN
  logic [15:0] stall_cnt;
`endif

  int          total = 0;
  int          bad = 0;
  logic [15:0] expQ [8][$];

  demux16b3_reg dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_sel(in_sel),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out0(out0),
    .out1(out1),
    .out2(out2),
    .out3(out3),
    .out4(out4),
    .out5(out5),
    .out6(out6),
    .out7(out7),
    .out_valid(out_valid),
    .out_ack(out_ack)
`ifdef DEMUX16B3_STALLCNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] getOut(input int k);
    case (k)
      0: return out0;
      1: return out1;
      2: return out2;
      3: return out3;
      4: return out4;
      5: return out5;
      6: return out6;
      default: return out7;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drives one cycle's inputs; a word the vector says will be accepted is queued for the monitor.
  task automatic applyStimulus(input logic v, input logic [2:0] sel, input logic [15:0] data,
                               input logic [7:0] ack, input logic expAccept);
    in_valid = v;
    in_sel   = sel;
    in_data  = data;
    out_ack  = ack;
    if (expAccept) expQ[sel].push_back(data);
    #1;
    if (v) checkOutput($sformatf("in_ready sel%0d", sel), {15'b0, in_ready}, {15'b0, expAccept});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic flushQueues;
    for (int k = 0; k < 8; k++) expQ[k].delete();
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int k = 0; k < 8; k++) begin
        if (out_valid[k] && out_ack[k]) begin
          if (expQ[k].size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL slot%0d unexpected word: got %h, expected none", k, getOut(k));
          end else begin
            checkOutput($sformatf("slot%0d word", k), getOut(k), expQ[k].pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    in_sel   = 3'd0;
    in_data  = 16'hFFFF;
    out_ack  = 8'h00;

    // Reset held with a live offer
    repeat (3) tick;
    checkOutput("reset out_valid", {8'h00, out_valid}, 16'h0000);
    checkOutput("reset in_ready", {15'b0, in_ready}, 16'h0000);
    for (int k = 0; k < 8; k++) checkOutput($sformatf("reset out%0d", k), getOut(k), 16'h0000);
`ifdef DEMUX16B3_STALLCNT_EN
    checkOutput("reset stall_cnt", stall_cnt, 16'h0000);
`endif
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("release in_ready", {15'b0, in_ready}, 16'h0001);

    // Fan-out to all eight slots
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, k[2:0], 16'hA0A0 + 16'(k), 8'h00, 1'b1);
      tick;
    end
    checkOutput("fanout out_valid", {8'h00, out_valid}, 16'h00FF);
    for (int k = 0; k < 8; k++) checkOutput($sformatf("fanout out%0d", k), getOut(k), 16'hA0A0 + 16'(k));
    applyStimulus(1'b1, 3'd3, 16'h5555, 8'h00, 1'b0);
    applyStimulus(1'b0, 3'd0, 16'h0000, 8'hFF, 1'b0);
    tick;
    applyStimulus(1'b0, 3'd0, 16'h0000, 8'h00, 1'b0);
    checkOutput("drain out_valid", {8'h00, out_valid}, 16'h0000);

    // Stall then release on slot 5, counter starting from a fresh reset
    rst = 1'b1;
    #1;
    rst = 1'b0;
    flushQueues();
    applyStimulus(1'b1, 3'd5, 16'h1234, 8'h00, 1'b1);
    tick;
    repeat (4) begin
      applyStimulus(1'b1, 3'd5, 16'hBEEF, 8'h00, 1'b0);
      tick;
    end
    applyStimulus(1'b1, 3'd5, 16'hBEEF, 8'h20, 1'b1);
    tick;
    applyStimulus(1'b0, 3'd0, 16'h0000, 8'h00, 1'b0);
    checkOutput("stall out5", out5, 16'hBEEF);
    checkOutput("stall out_valid", {8'h00, out_valid}, 16'h0020);
`ifdef DEMUX16B3_STALLCNT_EN
    checkOutput("stall_cnt after stall", stall_cnt, 16'h0004);
`endif
    applyStimulus(1'b0, 3'd0, 16'h0000, 8'h20, 1'b0);
    tick;
    applyStimulus(1'b0, 3'd0, 16'h0000, 8'h00, 1'b0);
    checkOutput("slot5 drained", {8'h00, out_valid}, 16'h0000);

    // Mixed acks alongside a write to another slot
    applyStimulus(1'b1, 3'd0, 16'h1111, 8'h00, 1'b1);
    tick;
    applyStimulus(1'b1, 3'd2, 16'h2222, 8'h00, 1'b1);
    tick;
    applyStimulus(1'b1, 3'd7, 16'h7777, 8'h00, 1'b1);
    tick;
    applyStimulus(1'b1, 3'd4, 16'h00FF, 8'b1000_0101, 1'b1);
    tick;
    applyStimulus(1'b0, 3'd0, 16'h0000, 8'h00, 1'b0);
    checkOutput("mixed out_valid", {8'h00, out_valid}, 16'h0010);
    checkOutput("mixed out4", out4, 16'h00FF);
    checkOutput("mixed out0", out0, 16'h1111);
    checkOutput("mixed out2", out2, 16'h2222);
    checkOutput("mixed out7", out7, 16'h7777);
    applyStimulus(1'b0, 3'd0, 16'h0000, 8'h10, 1'b0);
    tick;

    // Spurious acks on empty slots
    applyStimulus(1'b0, 3'd0, 16'h0000, 8'hFF, 1'b0);
    tick;
    tick;
    applyStimulus(1'b0, 3'd0, 16'h0000, 8'h00, 1'b0);
    checkOutput("spurious out_valid", {8'h00, out_valid}, 16'h0000);
    checkOutput("spurious out0", out0, 16'h1111);
    checkOutput("spurious out4", out4, 16'h00FF);
    checkOutput("spurious out5", out5, 16'hBEEF);
    checkOutput("spurious out7", out7, 16'h7777);

    // Asynchronous reset between edges with slots 2..5 full
    for (int k = 2; k < 6; k++) begin
      applyStimulus(1'b1, k[2:0], 16'hC000 + 16'(k), 8'h00, 1'b1);
      tick;
    end
    applyStimulus(1'b0, 3'd0, 16'h0000, 8'h00, 1'b0);
    checkOutput("pre-reset out_valid", {8'h00, out_valid}, 16'h003C);
    checkOutput("pre-reset out3", out3, 16'hC003);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async reset out_valid", {8'h00, out_valid}, 16'h0000);
    for (int k = 2; k < 6; k++) checkOutput($sformatf("async reset out%0d", k), getOut(k), 16'h0000);
    flushQueues();
    rst = 1'b0;
    tick;

`ifdef DEMUX16B3_STALLCNT_EN
    // Long stall drives the counter into saturation
    applyStimulus(1'b1, 3'd0, 16'h7777, 8'h00, 1'b1);
    tick;
    applyStimulus(1'b1, 3'd0, 16'h8888, 8'h00, 1'b0);
    repeat (70000) @(posedge clk);
    #1;
    checkOutput("stall_cnt saturated", stall_cnt, 16'hFFFF);
    repeat (5) tick;
    checkOutput("stall_cnt held", stall_cnt, 16'hFFFF);
    applyStimulus(1'b0, 3'd0, 16'h0000, 8'h00, 1'b0);
`endif

    // Every queued word must have been consumed
    applyStimulus(1'b0, 3'd0, 16'h0000, 8'hFF, 1'b0);
    tick;
    applyStimulus(1'b0, 3'd0, 16'h0000, 8'h00, 1'b0);
    for (int k = 0; k < 8; k++) checkOutput($sformatf("slot%0d leftover", k), 16'(expQ[k].size()), 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
